serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing diff = a - b
// (modulo 2^WIDTH) and borrow_out = (a < b). Operands are consumed LSB-first,
// one bit per clock, through a single full-subtractor cell and a borrow FF.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   a, b       minuend / subtrahend, captured when start is accepted
//   busy       high while an operation is running or completing
//   done       one-cycle pulse; diff/borrow_out hold the new result
//   diff       registered result, held until the next completion
//   borrow_out registered final borrow, held until the next completion
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_nxt;
  logic             d;
  logic             a0;
  logic             b0;
  logic             last;

  // Full-subtractor cell on the current LSBs.
  assign a0     = a_sh[0];
  assign b0     = b_sh[0];
  assign d      = a0 ^ b0 ^ br;
  assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign r_nxt  = {d, r_sh[WIDTH-1:1]};

  // The final RUN edge publishes the shifted-in result including this bit,
  // so completion is detected one count early.
  assign last   = (cnt == CW'(WIDTH - 1));

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            r_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff       <= r_nxt;
            borrow_out <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
